// File: rtl/serial_add.sv
// Bit-serial N-bit adder: add_rd = rs1_reg + rs2_reg + cin, W bits per clock, start/busy/done.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] rs1_reg,
    input  logic [N-1:0] rs2_reg,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] add_rd,
    output logic         co,
    output logic         ovf
);

    localparam int unsigned Steps = N / W;
    localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

    if ((N % W) != 0) begin : g_bad_width
        $error("serial_add: W (%0d) must divide N (%0d)", W, N);
    end

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            co_q, co_d;
    logic            done_q, done_d;
    logic [W:0]      slice_sum;
    logic [N-1:0]    sum_shift;

    assign slice_sum = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]} + (W + 1)'(carry_q);

    // New slice enters at the top; after Steps shifts the first slice sits at bit 0.
    if (W == N) begin : g_shift_full
        assign sum_shift = slice_sum[W-1:0];
    end else begin : g_shift_part
        assign sum_shift = {slice_sum[W-1:0], sum_q[N-1:W]};
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q, ovf_d;
    logic carry_into_msb;

    // Carry into the MSB recovered from its sum bit and operand bits.
    assign carry_into_msb = slice_sum[W-1] ^ a_q[W-1] ^ b_q[W-1];
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        co_d    = co_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = rs1_reg;
                    b_d     = rs2_reg;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d   = sum_shift;
                a_d     = a_q >> W;
                b_d     = b_q >> W;
                carry_d = slice_sum[W];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    co_d    = slice_sum[W];
                    done_d  = 1'b1;
                    state_d = StIdle;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_into_msb ^ slice_sum[W];
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            co_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            co_q    <= co_d;
            done_q  <= done_d;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = (state_q == StRun);
    assign done   = done_q;
    assign add_rd = sum_q;
    assign co     = co_q;

endmodule

// File: tb/tb_serial_add.sv
// Scoreboard bench for serial_add: W=1 and W=4 instances, directed vectors, queued expectations.
module tb_serial_add;

`ifdef SERIAL_ADD_OVF_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    exp_t q_w1[$];
    exp_t q_w4[$];

    logic        rst_w1, start_w1, cin_w1, busy_w1, done_w1, co_w1, ovf_w1;
    logic [15:0] rs1_w1, rs2_w1, add_rd_w1;
    logic        rst_w4, start_w4, cin_w4, busy_w4, done_w4, co_w4, ovf_w4;
    logic [15:0] rs1_w4, rs2_w4, add_rd_w4;

    serial_add #(.N(16), .W(1)) dut_w1 (
        .clk    (clk),
        .rst    (rst_w1),
        .start  (start_w1),
        .rs1_reg(rs1_w1),
        .rs2_reg(rs2_w1),
        .cin    (cin_w1),
        .busy   (busy_w1),
        .done   (done_w1),
        .add_rd (add_rd_w1),
        .co     (co_w1),
        .ovf    (ovf_w1)
    );

    serial_add #(.N(16), .W(4)) dut_w4 (
        .clk    (clk),
        .rst    (rst_w4),
        .start  (start_w4),
        .rs1_reg(rs1_w4),
        .rs2_reg(rs2_w4),
        .cin    (cin_w4),
        .busy   (busy_w4),
        .done   (done_w4),
        .add_rd (add_rd_w4),
        .co     (co_w4),
        .ovf    (ovf_w4)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitors: pop the oldest expectation whenever a done pulse is seen.
    always @(negedge clk) begin : mon_w1
        exp_t e;
        if (done_w1 === 1'b1) begin
            if (q_w1.size() == 0) begin
                check("w1_spurious_done", 32'(done_w1), 32'd0);
            end else begin
                e = q_w1.pop_front();
                check("w1_sum", 32'(add_rd_w1), 32'(e.sum));
                check("w1_co", 32'(co_w1), 32'(e.co));
                check("w1_ovf", 32'(ovf_w1), 32'(e.ovf));
                check("w1_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon_w4
        exp_t e;
        if (done_w4 === 1'b1) begin
            if (q_w4.size() == 0) begin
                check("w4_spurious_done", 32'(done_w4), 32'd0);
            end else begin
                e = q_w4.pop_front();
                check("w4_sum", 32'(add_rd_w4), 32'(e.sum));
                check("w4_co", 32'(co_w4), 32'(e.co));
                check("w4_ovf", 32'(ovf_w4), 32'(e.ovf));
                check("w4_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called just after a falling edge; the next rising edge accepts the start.
    task automatic issue(input bit w4, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input bit push, input logic [15:0] s,
                         input logic co_e, input logic ov_e);
        exp_t e;
        e.sum = s;
        e.co  = co_e;
        e.ovf = OvfEn & ov_e;
        e.cyc = cyc + 1 + (w4 ? 4 : 16);
        if (w4) begin
            rs1_w4 = a; rs2_w4 = b; cin_w4 = c; start_w4 = 1'b1;
            if (push) q_w4.push_back(e);
        end else begin
            rs1_w1 = a; rs2_w1 = b; cin_w1 = c; start_w1 = 1'b1;
            if (push) q_w1.push_back(e);
        end
        @(negedge clk);
        // Operands scrambled after capture must not disturb the result.
        if (w4) begin
            start_w4 = 1'b0; rs1_w4 = 16'($urandom); rs2_w4 = 16'($urandom); cin_w4 = 1'b1;
        end else begin
            start_w1 = 1'b0; rs1_w1 = 16'($urandom); rs2_w1 = 16'($urandom); cin_w1 = 1'b1;
        end
    endtask

    task automatic wait_done(input bit w4, input int exp_busy, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((w4 ? done_w4 : done_w1) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if ((w4 ? busy_w4 : busy_w1) === 1'b1) n++;
            @(negedge clk);
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        if (exp_busy >= 0) check({name, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    endtask

    initial begin
        rst_w1 = 1'b1; start_w1 = 1'b0; rs1_w1 = '0; rs2_w1 = '0; cin_w1 = 1'b0;
        rst_w4 = 1'b1; start_w4 = 1'b0; rs1_w4 = '0; rs2_w4 = '0; cin_w4 = 1'b0;
        repeat (3) @(negedge clk);
        rst_w1 = 1'b0;
        rst_w4 = 1'b0;
        check("rst_busy", 32'(busy_w1), 32'd0);
        check("rst_done", 32'(done_w1), 32'd0);
        check("rst_add_rd", 32'(add_rd_w1), 32'd0);
        check("rst_co", 32'(co_w1), 32'd0);
        check("rst_ovf", 32'(ovf_w1), 32'd0);
        check("rst_w4_busy", 32'(busy_w4), 32'd0);
        check("rst_w4_add_rd", 32'(add_rd_w4), 32'd0);

        issue(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
        wait_done(1'b0, 16, "one_plus_one");
        issue(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        wait_done(1'b0, 16, "wrap");
        issue(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        wait_done(1'b0, 16, "signed_ovf");

        // Start while busy is ignored.
        issue(1'b0, 16'h1111, 16'h2222, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rs1_w1 = 16'hAAAA; rs2_w1 = 16'h5555; cin_w1 = 1'b0; start_w1 = 1'b1;
        @(negedge clk);
        start_w1 = 1'b0;
        check("busy_during_restart", 32'(busy_w1), 32'd1);
        wait_done(1'b0, -1, "ignored_restart");
        // Back-to-back start in the done cycle.
        issue(1'b0, 16'hAAAA, 16'h5555, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        wait_done(1'b0, 16, "back_to_back");

        // Reset aborts an operation; no done may follow.
        issue(1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        rst_w1 = 1'b1;
        @(negedge clk);
        rst_w1 = 1'b0;
        check("abort_busy", 32'(busy_w1), 32'd0);
        check("abort_add_rd", 32'(add_rd_w1), 32'd0);
        check("abort_co", 32'(co_w1), 32'd0);
        check("abort_ovf", 32'(ovf_w1), 32'd0);
        repeat (20) @(negedge clk);
        issue(1'b0, 16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0);
        wait_done(1'b0, 16, "after_abort");

        issue(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1, 16'h5556, 1'b0, 1'b0);
        wait_done(1'b1, 4, "w4_basic");
        issue(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        wait_done(1'b1, 4, "w4_wrap");
        issue(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        wait_done(1'b1, 4, "w4_signed_ovf");

        repeat (3) @(negedge clk);
        check("w1_queue_drained", 32'(q_w1.size()), 32'd0);
        check("w4_queue_drained", 32'(q_w4.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
